pstore_access: RTL and testbench
================================

# pstore_access

Processor-store access port: the requester-side counterpart to the processor store's recirculating delay line. It tracks the serial bit/word position of the delay line from a bit strobe and word-sync marker. It accepts one read or write request at a time for a 4-bit word slot, waits for that slot to reach the line, and then substitutes new bits into the delay-line input (write) or captures the outgoing bits (read). At all other times it recirculates the line unchanged.

## Interface
- WORDS, 8: 4-bit word slots held in the delay line; power of two, ≥2.
- SLOT_W, $clog2(WORDS): slot index width (derived).
- SIM_CLK  in  1  simulation clock, sole clock.
- SIM_RST  in  1  reset, synchronous, active-high.
- BT  in  1  bit-time strobe, one SIM_CLK cycle per delay-line bit; ≥2 cycles apart.
- SYNC  in  1  word-sync marker; meaningful only with BT; marks slot 0 bit 0.
- DLO  in  1  delay-line output bit; sampled only when BT=1.
- DIN  out  1  delay-line input bit; registered.
- REQ  in  1  request valid.
- REQ_WR  in  1  1=write, 0=read.
- REQ_SLOT  in  SLOT_W  target slot.
- REQ_DATA  in  4  write data; bit 0 goes first.
- ACK  out  1  ready; the request is taken on any cycle with REQ&ACK.
- DONE  out  1  one-cycle completion pulse.
- XERR  out  1  valid with DONE; 1=transfer aborted.
- RD_DATA  out  4  last completed read word; held.
- LOCKED  out  1  SYNC has been seen since reset.
- SYNC_ERR  out  1  one-cycle pulse on a misaligned SYNC.

## Operation
- Position (wpos, bpos) names the bit sampled on the current BT. It advances after each BT: bpos 0→3, then wpos+1 mod WORDS.
- A BT with SYNC forces the position to (0,0) for that bit. If LOCKED and the expected position ≠ (0,0), SYNC_ERR pulses.
- LOCKED sets on the first BT&SYNC and clears only on reset.
- Default on every BT: DIN ← DLO (recirculate), including while unlocked.
- ACK = LOCKED & state==IDLE. Taking a request latches REQ_WR, REQ_SLOT and REQ_DATA and enters WAIT.
- States:
  - IDLE: ACK may be high.
  - WAIT: on a BT with position == (slot,0), go to XFER and process bit 0 on that same BT.
  - XFER: on each BT at (slot,b), write sets DIN ← data[b]; read captures DLO into shift bit b, and DIN ← DLO (non-destructive). After bit 3, go to DONE.
  - DONE: DONE=1 for one cycle. XERR=0. A read updates RD_DATA on this cycle. Then go to IDLE.
- SYNC_ERR while in WAIT: realign and keep waiting at the new alignment.
- SYNC_ERR while in XFER: abort. Bits already written stay; remaining bits recirculate. Go to DONE with XERR=1; RD_DATA is not updated.
- A REQ on the same cycle as a BT is accepted, but that BT is never used for the transfer.

## Timing
- Reset values: DIN=0, ACK=0, DONE=0, XERR=0, RD_DATA=0, LOCKED=0, SYNC_ERR=0, state IDLE, position (0,0). Any in-flight transfer is dropped without DONE.
- DIN changes the cycle after each BT and holds between BTs.
- SYNC_ERR is asserted the cycle after the offending BT.
- DONE is asserted the cycle after the BT of bit 3. ACK returns one cycle after DONE.
- Request-to-DONE latency, counted in BTs: 1 to 4·WORDS BTs of wait, plus 3 BTs of transfer, plus 1 cycle.
- Slot WORDS−1 bit 3 wraps to slot 0 bit 0. A target of slot 0 is reached at the wrap.

## Structure
- Package pstore_pkg holds:
  - the state enum (IDLE, WAIT, XFER, DONE);
  - the constant PS_BITS=4;
  - the position struct {wpos, bpos}.
- Sub-module pstore_pos_counter holds the BT/SYNC position tracker, LOCKED and SYNC_ERR generation. The top level keeps the FSM, the DIN mux and the read shift register.

## Test plan
All scenarios use WORDS=8, BT every 4 cycles, and a behavioural 32-bit delay-line model.
- Unlocked recirculation: preload the line with 0xA5A5A5A5 and issue no SYNC. DIN mirrors DLO one cycle after each BT. ACK stays 0 and REQ is ignored.
- Write slot 5, data 0xC: after lock, slots 5 reads back 0xC on the next pass. All other slots are unchanged. DONE=1 with XERR=0.
- Read slot 0 with the line preloaded 0x3 there: the request is taken at wpos 6. RD_DATA=0x3 after the wrap. DONE is asserted 1 cycle after the slot-0 bit-3 BT. The line is unchanged.
- Back-to-back: a write to slot 2 (0x9), then a read of slot 2 issued the cycle ACK returns. The read returns 0x9. ACK=0 throughout both transfers.
- Misaligned SYNC during XFER at bit 2 of a write of 0xF over 0x0: SYNC_ERR pulses. DONE=1 with XERR=1. The slot holds 0x3.
- SIM_RST during WAIT: the cycle after, all outputs are at reset values. No DONE appears, and a new SYNC is needed before ACK=1.

Source files
------------

// File: rtl/pstore_pkg.sv
// Shared types for the processor-store access port: FSM states, word width
// and the serial (word, bit) position of the recirculating delay line.
package pstore_pkg;
  localparam int PS_BITS   = 4;
  localparam int PS_BPOS_W = $clog2(PS_BITS);
  localparam int PS_WPOS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } ps_state_e;

  typedef struct packed {
    logic [PS_WPOS_W-1:0] wpos;
    logic [PS_BPOS_W-1:0] bpos;
  } ps_pos_t;
endpackage

// File: rtl/pstore_access_if.sv
// Request/response bundle between a requester and the delay-line access port.
// A request is taken on any cycle with REQ & ACK; DONE/XERR/RD_DATA report back.
interface pstore_access_if #(parameter int WORDS = 8) ();
  localparam int SLOT_W = $clog2(WORDS);

  logic              REQ;
  logic              REQ_WR;
  logic [SLOT_W-1:0] REQ_SLOT;
  logic [3:0]        REQ_DATA;
  logic              ACK;
  logic              DONE;
  logic              XERR;
  logic [3:0]        RD_DATA;

  modport master (output REQ, REQ_WR, REQ_SLOT, REQ_DATA,
                  input  ACK, DONE, XERR, RD_DATA);
  modport slave  (input  REQ, REQ_WR, REQ_SLOT, REQ_DATA,
                  output ACK, DONE, XERR, RD_DATA);
endinterface

// File: rtl/pstore_pos_counter.sv
// Tracks the (word, bit) position of the bit on the line at each BT; SYNC forces
// (0,0). Raises LOCKED on the first SYNC and a registered pulse on a misaligned SYNC.
module pstore_pos_counter
  import pstore_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    bt_i,
  input  logic    sync_i,
  output ps_pos_t pos_o,
  output logic    sync_mis_o,
  output logic    locked_o,
  output logic    sync_err_o
);
  ps_pos_t pos_q, pos_d, nxt;
  logic    locked_q, locked_d;
  logic    serr_q, serr_d;

  always_comb begin
    pos_o      = sync_i ? '0 : pos_q;
    sync_mis_o = bt_i & sync_i & locked_q & (pos_q != '0);
    nxt        = pos_o;
    if (pos_o.bpos == PS_BPOS_W'(PS_BITS - 1)) begin
      nxt.bpos = '0;
      nxt.wpos = (pos_o.wpos == PS_WPOS_W'(WORDS - 1)) ? '0 : pos_o.wpos + 1'b1;
    end else begin
      nxt.bpos = pos_o.bpos + 1'b1;
    end
    pos_d    = bt_i ? nxt : pos_q;
    locked_d = locked_q | (bt_i & sync_i);
    serr_d   = sync_mis_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q    <= '0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
    end
  end

  assign locked_o   = locked_q;
  assign sync_err_o = serr_q;
endmodule

// File: rtl/pstore_access.sv
// Delay-line access port: waits for the requested slot, then overwrites (write) or
// copies out (read) its 4 bits while the rest of the line recirculates unchanged.
module pstore_access
  import pstore_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic BT,
  input  logic SYNC,
  input  logic DLO,
  output logic DIN,
  output logic LOCKED,
  output logic SYNC_ERR,
  pstore_access_if.slave bus
);
  localparam int SLOT_W = $clog2(WORDS);

  ps_pos_t           pos;
  logic              sync_mis;
  ps_state_e         state_q, state_d;
  logic              wr_q, wr_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PS_BITS-1:0] data_q, data_d;
  logic [PS_BITS-1:0] sh_q, sh_d;
  logic [PS_BITS-1:0] rd_q, rd_d;
  logic              xerr_q, xerr_d;
  logic              din_q, din_d;
  logic              ack, at_start, do_bit;

  pstore_pos_counter #(.WORDS(WORDS)) u_pos (
    .clk_i      (SIM_CLK),
    .rst_i      (SIM_RST),
    .bt_i       (BT),
    .sync_i     (SYNC),
    .pos_o      (pos),
    .sync_mis_o (sync_mis),
    .locked_o   (LOCKED),
    .sync_err_o (SYNC_ERR)
  );

  always_comb begin
    ack      = LOCKED & (state_q == IDLE);
    at_start = BT && (pos.bpos == '0) && (pos.wpos == PS_WPOS_W'(slot_q));
    do_bit   = ((state_q == WAIT) && at_start) || ((state_q == XFER) && BT && !sync_mis);

    state_d = state_q;
    wr_d    = wr_q;
    slot_d  = slot_q;
    data_d  = data_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    xerr_d  = xerr_q;
    din_d   = BT ? DLO : din_q;

    // Reads leave the line intact: DIN keeps the recirculated DLO bit.
    if (do_bit) begin
      if (wr_q) din_d = data_q[pos.bpos];
      else      sh_d[pos.bpos] = DLO;
    end

    case (state_q)
      IDLE: if (ack && bus.REQ) begin
        wr_d    = bus.REQ_WR;
        slot_d  = bus.REQ_SLOT;
        data_d  = bus.REQ_DATA;
        state_d = WAIT;
      end
      WAIT: if (do_bit) state_d = XFER;
      XFER: begin
        if (BT && sync_mis) begin
          xerr_d  = 1'b1;
          state_d = DONE;
        end else if (do_bit && (pos.bpos == PS_BPOS_W'(PS_BITS - 1))) begin
          xerr_d  = 1'b0;
          state_d = DONE;
          if (!wr_q) rd_d = sh_d;
        end
      end
      DONE: begin
        xerr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      slot_q  <= '0;
      data_q  <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      xerr_q  <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      xerr_q  <= xerr_d;
      din_q   <= din_d;
    end
  end

  assign DIN         = din_q;
  assign bus.ACK     = ack;
  assign bus.DONE    = (state_q == DONE);
  assign bus.XERR    = xerr_q;
  assign bus.RD_DATA = rd_q;
endmodule

// File: tb/tb_pstore_access.sv
// Bench for pstore_access: a 32-bit delay-line model feeds DLO and absorbs DIN,
// requests push expected responses into a queue, a monitor pops them on DONE.
module tb_pstore_access;
  localparam int WORDS = 8;
  localparam int NBITS = 4 * WORDS;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic BT = 1'b0, SYNC = 1'b0, DLO = 1'b0;
  wire  DIN, LOCKED, SYNC_ERR;

  pstore_access_if #(.WORDS(WORDS)) bus ();

  pstore_access #(.WORDS(WORDS)) dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .BT       (BT),
    .SYNC     (SYNC),
    .DLO      (DLO),
    .DIN      (DIN),
    .LOCKED   (LOCKED),
    .SYNC_ERR (SYNC_ERR),
    .bus      (bus)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int vectors = 0, miscompares = 0;

  task automatic check(string name, int act, int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Delay-line model: bit p leaves on DLO at a BT, DIN re-enters it one cycle later.
  logic [NBITS-1:0] line;
  int   p = 0, cyc = 0;
  bit   run = 0, sync_en = 0, check_recirc = 0, inject_arm = 0;
  int   inject_p = 0, inject_cyc = -1;
  bit   prev_bt = 0;
  int   prev_p = 0;
  logic prev_dlo = 1'b0;
  int   last_bt_cyc = -100, last_bt_p = -1;

  always @(negedge SIM_CLK) begin
    cyc++;
    if (prev_bt) begin
      line[prev_p] = DIN;
      if (check_recirc) check("recirc_din", int'(DIN), int'(prev_dlo));
    end
    prev_bt = 0;
    if (run && (cyc % 4 == 0)) begin
      BT   = 1'b1;
      DLO  = line[p];
      SYNC = (sync_en && p == 0) || (inject_arm && p == inject_p);
      if (inject_arm && p == inject_p) begin
        inject_arm = 0;
        inject_cyc = cyc;
      end
      prev_bt     = 1;
      prev_p      = p;
      prev_dlo    = line[p];
      last_bt_cyc = cyc;
      last_bt_p   = p;
      p           = (p + 1) % NBITS;
    end else begin
      BT   = 1'b0;
      SYNC = 1'b0;
    end
  end

  typedef struct {
    bit wr;
    int slot;
    int xerr;
    int rd;
    int endp;
  } exp_t;

  exp_t       sb[$];
  bit         busy = 0, ack_viol = 0, inject_checked = 0;
  logic [3:0] mem_exp [WORDS];
  int         serr_cnt = 0;

  // Monitor: independent of stimulus, compares every DONE against the queue head.
  always @(negedge SIM_CLK) begin
    exp_t e;
    #2;
    if (busy && bus.ACK) ack_viol = 1;
    if (SYNC_ERR) begin
      serr_cnt++;
      if (inject_cyc >= 0 && !inject_checked) begin
        check("serr_timing", cyc - inject_cyc, 1);
        inject_checked = 1;
      end
    end
    if (bus.DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("xerr", int'(bus.XERR), e.xerr);
        if (!e.wr && e.xerr == 0) check("rd_data", int'(bus.RD_DATA), e.rd);
        check("done_latency", cyc - last_bt_cyc, 1);
        check("done_bitpos", last_bt_p, e.endp);
        check("ack_low_busy", int'(ack_viol), 0);
      end
      busy     = 0;
      ack_viol = 0;
    end
  end

  task automatic issue(bit wr, int slot, logic [3:0] data, int want_w, bit abort);
    int   n = 0;
    exp_t e;
    logic [3:0] old;
    @(negedge SIM_CLK); #1;
    while (!(bus.ACK && (want_w < 0 || p / 4 == want_w))) begin
      n++;
      if (n > 3000) begin
        check("ack_timeout", 0, 1);
        return;
      end
      @(negedge SIM_CLK); #1;
    end
    bus.REQ      = 1'b1;
    bus.REQ_WR   = wr;
    bus.REQ_SLOT = 3'(slot);
    bus.REQ_DATA = data;
    @(negedge SIM_CLK); #1;
    bus.REQ = 1'b0;
    e.wr   = wr;
    e.slot = slot;
    e.xerr = abort ? 1 : 0;
    e.rd   = int'(mem_exp[slot]);
    e.endp = slot * 4 + (abort ? 2 : 3);
    // An abort at bit 2 keeps bits 0..1 of the new data and the old upper bits.
    old = mem_exp[slot];
    if (wr) mem_exp[slot] = abort ? {old[3:2], data[1:0]} : data;
    sb.push_back(e);
    busy = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge SIM_CLK); #1;
      n++;
    end
    check("idle_timeout", int'(sb.size() != 0 || busy), 0);
  endtask

  task automatic wait_lock();
    int n = 0;
    while (!LOCKED && n < 400) begin
      @(negedge SIM_CLK); #1;
      n++;
    end
    check("lock", int'(LOCKED), 1);
  endtask

  task automatic check_line();
    for (int w = 0; w < WORDS; w++)
      check($sformatf("line_slot%0d", w), int'(line[w*4 +: 4]), int'(mem_exp[w]));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_din"},     int'(DIN), 0);
    check({tag, "_ack"},     int'(bus.ACK), 0);
    check({tag, "_done"},    int'(bus.DONE), 0);
    check({tag, "_xerr"},    int'(bus.XERR), 0);
    check({tag, "_rd_data"}, int'(bus.RD_DATA), 0);
    check({tag, "_locked"},  int'(LOCKED), 0);
    check({tag, "_syncerr"}, int'(SYNC_ERR), 0);
  endtask

  task automatic unlocked_window(int cycles);
    int n_ack = 0;
    check_recirc = 1;
    repeat (cycles) begin
      @(negedge SIM_CLK); #1;
      if (bus.ACK) n_ack++;
    end
    check_recirc = 0;
    check("unlocked_ack", n_ack, 0);
    check("unlocked_locked", int'(LOCKED), 0);
  endtask

  initial begin
    int s0;
    bus.REQ = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_SLOT = '0; bus.REQ_DATA = '0;
    line = 32'hA5A5A5A5;
    for (int w = 0; w < WORDS; w++) mem_exp[w] = line[w*4 +: 4];

    repeat (3) @(negedge SIM_CLK);
    #1;
    check_reset_outputs("reset");
    SIM_RST = 1'b0;
    run     = 1;

    // Unlocked: line recirculates, a held REQ is never taken.
    bus.REQ = 1'b1; bus.REQ_WR = 1'b1; bus.REQ_SLOT = 3'd1; bus.REQ_DATA = 4'hF;
    unlocked_window(160);
    bus.REQ = 1'b0;
    check_line();

    sync_en = 1;
    wait_lock();

    issue(1, 5, 4'hC, -1, 0);
    wait_idle();
    check_line();
    issue(0, 5, 4'h0, -1, 0);
    wait_idle();

    issue(1, 0, 4'h3, -1, 0);
    wait_idle();
    issue(0, 0, 4'h0, 6, 0);
    wait_idle();
    check_line();

    // Back-to-back: the read is issued on the first cycle ACK returns.
    issue(1, 2, 4'h9, -1, 0);
    issue(0, 2, 4'h0, -1, 0);
    wait_idle();

    // Misaligned SYNC on bit 2 of a write; the following true SYNC is misaligned too.
    issue(1, 3, 4'h0, -1, 0);
    wait_idle();
    s0 = serr_cnt;
    issue(1, 3, 4'hF, 6, 1);
    inject_p   = 3 * 4 + 2;
    inject_arm = 1;
    wait_idle();
    repeat (160) @(negedge SIM_CLK);
    #1;
    check("serr_count", serr_cnt - s0, 2);
    check("inject_seen", int'(inject_checked), 1);
    check_line();

    // Reset while a read waits for slot 7.
    issue(0, 7, 4'h0, 0, 0);
    while (cyc % 4 != 1) begin
      @(negedge SIM_CLK); #1;
    end
    SIM_RST = 1'b1;
    @(negedge SIM_CLK); #1;
    SIM_RST = 1'b0;
    sb.delete();
    busy     = 0;
    ack_viol = 0;
    check_reset_outputs("midrst");
    sync_en = 0;
    unlocked_window(160);
    check_line();
    sync_en = 1;
    wait_lock();

    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, WORDS - 1),
            4'($urandom_range(0, 15)), -1, 0);
      repeat ($urandom_range(0, 6)) @(negedge SIM_CLK);
    end
    wait_idle();
    check_line();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
